mpa_rf_wb_arbiter: RTL and testbench
====================================

// Module: mpa_rf_wb_arbiter
// PURPOSE
//  Sole owner of the 32x32 MIPS register-file write port (WE/A2/DIN).
//  Arbitrates NUM_REQ writeback sources (ALU, load, mul/div) onto that port using valid/ready.
//  Keeps a pending-write scoreboard so decode can check read operands (A0/A1) for RAW hazards.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  NUM_REQ   3    number of writeback requesters (2..8); index 0 = lowest index
//  AW        5    register address width (fixed by ISA, not to be overridden)
//  DW        32   data width (fixed by ISA, not to be overridden)
// PORTS
//  CLK        in   1           single clock; all state updates on posedge
//  HW_RST     in   1           one clock; reset is synchronous and active-high
//  REQ_VALID  in   NUM_REQ     per-requester write request
//  REQ_READY  out  NUM_REQ     per-requester grant; at most one bit high
//  REQ_ADDR   in   NUM_REQ*AW  destination reg, requester i at [i*AW +: AW]
//  REQ_DATA   in   NUM_REQ*DW  write data, requester i at [i*DW +: DW]
//  RF_WE      out  1           register-file write enable (registered)
//  RF_A2      out  AW          register-file write address (registered)
//  RF_DIN     out  DW          register-file write data (registered)
//  RES_SET    in   1           decode reserves a destination register
//  RES_ADDR   in   AW          register being reserved
//  CHK_A0     in   AW          operand address 0 to check
//  CHK_A1     in   AW          operand address 1 to check
//  CHK_BUSY0  out  1           CHK_A0 has a pending write (combinational from state)
//  CHK_BUSY1  out  1           CHK_A1 has a pending write
//  BUSY_CNT   out  6           number of busy scoreboard bits (popcount, 0..31)
//  SB_ERR     out  1           sticky scoreboard protocol error
// BEHAVIOUR
//  - Reset: RF_WE=0, RF_A2=0, RF_DIN=0, rr_ptr=0, busy[31:0]=0, SB_ERR=0.
//  - Reset dominates every other event in the same cycle.
//  - Reset mid-operation drops any accepted-but-unwritten request without warning.
//  - Arbitration (round-robin):
//    - Search order starts at rr_ptr and wraps at NUM_REQ-1 -> 0.
//    - REQ_READY[i]=1 only for the first i found with REQ_VALID[i]=1; combinational.
//    - Requesters must not make VALID depend on READY.
//    - Accept = VALID & READY. On accept, rr_ptr <= (winner+1) mod NUM_REQ.
//    - With no accept, rr_ptr holds.
//  - Latency: accept in cycle N -> RF_WE=1 with winner's ADDR/DATA in cycle N+1.
//    - RF_WE deasserts the next cycle unless another accept occurs; full throughput is 1 write/cycle.
//    - RF_A2/RF_DIN hold their last value while RF_WE=0.
//  - Address 0 request:
//    - Still accepted (READY given, pointer rotates), but RF_WE stays 0 for it.
//    - Scoreboard untouched.
//  - Scoreboard busy[31:1]; busy[0] is hardwired 0.
//    - Set: RES_SET=1 and RES_ADDR!=0 -> busy[RES_ADDR]<=1.
//    - Clear: on the edge ending a cycle with RF_WE=1, busy[RF_A2]<=0. Data and busy=0 are visible in the same cycle.
//    - Set and clear on the same address in the same cycle: set wins. The register stays busy for the new writer.
//    - RES_SET on an already-busy register: SB_ERR<=1; bit stays set.
//    - RF_WE to a register that is not busy: SB_ERR<=1; write still performed.
//    - SB_ERR clears only on HW_RST.
//  - CHK_BUSYx = busy[CHK_Ax]; address 0 always reads 0. No bypass of same-cycle set/clear.
//  - BUSY_CNT = registered popcount of busy, updated one cycle after the busy change.
// CONFIGURATION
//  - MPA_WB_FIXED_PRIO_EN defined:
//    - Fixed priority, lowest asserted index wins.
//    - rr_ptr is removed; everything else is unchanged.
//  - Not defined: round-robin as described above.
// TESTING
//  - Reset: assert HW_RST for 2 cycles with all VALID=1 -> READY still one-hot per priority rule, RF_WE=0, BUSY_CNT=0, SB_ERR=0 after release.
//  - Round-robin, all three VALID held with ADDR 5/6/7 and DATA A/B/C:
//    - Grants go 0,1,2,0.
//    - RF_WE=1 on consecutive cycles with A2=5,6,7,5, each one cycle after its accept.
//  - Scoreboard:
//    - RES_SET addr 9 -> CHK_A0=9 gives BUSY0=1, BUSY_CNT=1.
//    - Requester 1 writes r9 -> BUSY0=0 in the cycle after RF_WE. SB_ERR=0.
//  - Collision: RF_WE to r4 while RES_SET r4 in the same cycle -> busy[4] stays 1, SB_ERR=0.
//  - Errors:
//    - Request to r0 with data FFFF_FFFF -> READY=1, RF_WE=0.
//    - RES_SET r3 twice -> SB_ERR=1 and it stays 1 until HW_RST.
//  - Fixed-priority build (MPA_WB_FIXED_PRIO_EN), VALID=3'b111 held -> requester 0 granted every cycle, requesters 1 and 2 starve.

Source files
------------

// File: rtl/mpa_rf_wb_arbiter_if.sv
// Writeback request bundle: NUM_REQ requesters presenting destination register and data.
// Handshake: a transfer happens on a rising edge where REQ_VALID[i] & REQ_READY[i]; VALID must not depend on READY.
interface mpa_rf_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 5,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    REQ_VALID;
    logic [NUM_REQ-1:0]    REQ_READY;
    logic [NUM_REQ*AW-1:0] REQ_ADDR;
    logic [NUM_REQ*DW-1:0] REQ_DATA;

    modport master (
        output REQ_VALID,
        output REQ_ADDR,
        output REQ_DATA,
        input  REQ_READY
    );

    modport slave (
        input  REQ_VALID,
        input  REQ_ADDR,
        input  REQ_DATA,
        output REQ_READY
    );
endinterface

// File: rtl/mpa_rf_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard for RAW hazard checks.
// Define MPA_WB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mpa_rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int AW      = 5,
    parameter int DW      = 32
) (
    input  logic           CLK,
    input  logic           HW_RST,
    mpa_rf_wb_arbiter_if.slave req,
    output logic           RF_WE,
    output logic [AW-1:0]  RF_A2,
    output logic [DW-1:0]  RF_DIN,
    input  logic           RES_SET,
    input  logic [AW-1:0]  RES_ADDR,
    input  logic [AW-1:0]  CHK_A0,
    input  logic [AW-1:0]  CHK_A1,
    output logic           CHK_BUSY0,
    output logic           CHK_BUSY1,
    output logic [5:0]     BUSY_CNT,
    output logic           SB_ERR
);
    localparam int NREG = 1 << AW;

    logic            rf_we_q;
    logic [AW-1:0]   rf_a2_q;
    logic [DW-1:0]   rf_din_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            sb_err_q;
    logic            sb_err_d;
    logic [5:0]      busy_cnt_q;

    logic            win_found;
    int              win_idx;
    int              scan;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;
    logic            wr_en_d;
    logic            res_hit;
    logic            clr_same;

`ifndef MPA_WB_FIXED_PRIO_EN
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
`endif

    // Winner search: the first valid requester met, starting at the priority origin.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        win_addr  = '0;
        win_data  = '0;
        scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef MPA_WB_FIXED_PRIO_EN
            scan = k;
`else
            scan = int'(rr_ptr_q) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
`endif
            if (!win_found && req.REQ_VALID[scan]) begin
                win_found = 1'b1;
                win_idx   = scan;
                win_addr  = req.REQ_ADDR[scan*AW +: AW];
                win_data  = req.REQ_DATA[scan*DW +: DW];
            end
        end
    end

    always_comb begin
        req.REQ_READY = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req.REQ_READY[i] = win_found && (win_idx == i);
        end
    end

    // Writes to r0 are accepted and discarded.
    assign wr_en_d = win_found && (win_addr != '0);

`ifndef MPA_WB_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_found) begin
            if (win_idx == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = PW'(win_idx + 1);
            end
        end
    end
`endif

    // A reservation landing on the register being retired this cycle is a legal hand-over, set wins.
    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        res_hit  = RES_SET && (RES_ADDR != '0);
        clr_same = rf_we_q && (rf_a2_q == RES_ADDR);
        if (rf_we_q && !busy_q[rf_a2_q]) begin
            sb_err_d = 1'b1;
        end
        if (res_hit && busy_q[RES_ADDR] && !clr_same) begin
            sb_err_d = 1'b1;
        end
        if (rf_we_q) begin
            busy_d[rf_a2_q] = 1'b0;
        end
        if (res_hit) begin
            busy_d[RES_ADDR] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    function automatic logic [5:0] popcnt(input logic [NREG-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

    always_ff @(posedge CLK) begin
        if (HW_RST) begin
            rf_we_q    <= 1'b0;
            rf_a2_q    <= '0;
            rf_din_q   <= '0;
            busy_q     <= '0;
            sb_err_q   <= 1'b0;
            busy_cnt_q <= '0;
`ifndef MPA_WB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            rf_we_q <= wr_en_d;
            if (wr_en_d) begin
                rf_a2_q  <= win_addr;
                rf_din_q <= win_data;
            end
            busy_q     <= busy_d;
            sb_err_q   <= sb_err_d;
            busy_cnt_q <= popcnt(busy_q);
`ifndef MPA_WB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign RF_WE     = rf_we_q;
    assign RF_A2     = rf_a2_q;
    assign RF_DIN    = rf_din_q;
    assign CHK_BUSY0 = busy_q[CHK_A0];
    assign CHK_BUSY1 = busy_q[CHK_A1];
    assign BUSY_CNT  = busy_cnt_q;
    assign SB_ERR    = sb_err_q;
endmodule

// File: tb/tb_mpa_rf_wb_arbiter.sv
// Bench for mpa_rf_wb_arbiter: directed scenarios then random traffic against a reference model.
module tb_mpa_rf_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpa_rf_wb_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

    logic          rf_we;
    logic [AW-1:0] rf_a2;
    logic [DW-1:0] rf_din;
    logic          res_set = 1'b0;
    logic [AW-1:0] res_addr = '0;
    logic [AW-1:0] chk_a0 = '0;
    logic [AW-1:0] chk_a1 = '0;
    logic          chk_busy0;
    logic          chk_busy1;
    logic [5:0]    busy_cnt;
    logic          sb_err;

    mpa_rf_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .CLK       (clk),
        .HW_RST    (rst),
        .req       (bus.slave),
        .RF_WE     (rf_we),
        .RF_A2     (rf_a2),
        .RF_DIN    (rf_din),
        .RES_SET   (res_set),
        .RES_ADDR  (res_addr),
        .CHK_A0    (chk_a0),
        .CHK_A1    (chk_a1),
        .CHK_BUSY0 (chk_busy0),
        .CHK_BUSY1 (chk_busy1),
        .BUSY_CNT  (busy_cnt),
        .SB_ERR    (sb_err)
    );

    initial begin
        bus.REQ_VALID = '1;
        bus.REQ_ADDR  = '0;
        bus.REQ_DATA  = '0;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Expected register-file writes, {addr, data}, in issue order.
    logic [AW+DW-1:0] exp_q[$];

    // Reference model state as seen after the most recent rising edge.
    int          m_rr   = 0;
    logic [31:0] m_busy = '0;
    logic        m_err  = 1'b0;
    int          m_cnt  = 0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_a2   = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [N*AW-1:0] pa(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [N*DW-1:0] pd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        return {d2, d1, d0};
    endfunction

    task automatic drive_cycle(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                               input logic [N*DW-1:0] d, input logic rs, input logic [4:0] ra,
                               input logic [4:0] c0, input logic [4:0] c1);
        int w;
        int idx;
        logic [N-1:0] exp_ready;
        logic [4:0] wa;
        @(negedge clk);
        rst           = r;
        bus.REQ_VALID = v;
        bus.REQ_ADDR  = a;
        bus.REQ_DATA  = d;
        res_set       = rs;
        res_addr      = ra;
        chk_a0        = c0;
        chk_a1        = c1;
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
`ifdef MPA_WB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_rr + k) % N;
`endif
            if (w < 0 && v[idx]) w = idx;
        end
        exp_ready = '0;
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("ready", 64'(bus.REQ_READY), 64'(exp_ready));
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("chk_busy0", 64'(chk_busy0), 64'(m_busy[c0]));
        chk("chk_busy1", 64'(chk_busy1), 64'(m_busy[c1]));
        chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt));
        chk("sb_err", 64'(sb_err), 64'(m_err));
        if (r) begin
            m_rr = 0; m_busy = '0; m_err = 1'b0; m_cnt = 0; m_we = 1'b0; m_a2 = '0;
        end else begin
            m_cnt = $countones(m_busy);
            if (m_we && !m_busy[m_a2]) m_err = 1'b1;
            if (rs && ra != 0 && m_busy[ra] && !(m_we && m_a2 == ra)) m_err = 1'b1;
            if (m_we) m_busy[m_a2] = 1'b0;
            if (rs && ra != 0) m_busy[ra] = 1'b1;
            m_we = 1'b0;
            if (w >= 0) begin
                m_rr = (w + 1) % N;
                wa = a[w*AW +: AW];
                if (wa != 0) begin
                    m_we = 1'b1;
                    m_a2 = wa;
                    exp_q.push_back({wa, d[w*DW +: DW]});
                end
            end
        end
    endtask

    task automatic idle(input logic [4:0] c0);
        drive_cycle(1'b0, '0, '0, '0, 1'b0, 5'd0, c0, 5'd0);
    endtask

    task automatic reserve(input logic [4:0] ra, input logic [4:0] c0);
        drive_cycle(1'b0, '0, '0, '0, 1'b1, ra, c0, 5'd0);
    endtask

    // Monitor: every register-file write is matched against the oldest expected write.
    initial begin
        logic [AW+DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t", rf_a2, rf_din, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", 64'(rf_a2), 64'(e[AW+DW-1:DW]));
                    chk("wb_data", 64'(rf_din), 64'(e[DW-1:0]));
                end
            end
        end
    end

    initial begin
        logic [N*AW-1:0] ra_v;
        logic [N*DW-1:0] rd_v;
        // Reset held two cycles with every requester asking.
        repeat (2) drive_cycle(1'b1, 3'b111, pa(5, 6, 7), pd(32'hA, 32'hB, 32'hC), 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);

        // Round-robin over three held requests to r5/r6/r7.
        reserve(5'd5, 5'd5);
        reserve(5'd6, 5'd5);
        reserve(5'd7, 5'd6);
        repeat (4) drive_cycle(1'b0, 3'b111, pa(5, 6, 7), pd(32'hA, 32'hB, 32'hC), 1'b0, 5'd0, 5'd5, 5'd7);
        idle(5'd5);
        idle(5'd7);
        drive_cycle(1'b1, '0, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);

        // Reserve r9 then retire it from requester 1.
        reserve(5'd9, 5'd9);
        idle(5'd9);
        idle(5'd9);
        drive_cycle(1'b0, 3'b010, pa(0, 9, 0), pd(0, 32'h1234_5678, 0), 1'b0, 5'd0, 5'd9, 5'd0);
        repeat (3) idle(5'd9);

        // Re-reservation of r4 in the same cycle its write retires.
        reserve(5'd4, 5'd4);
        drive_cycle(1'b0, 3'b001, pa(4, 0, 0), pd(32'hCAFE_0004, 0, 0), 1'b0, 5'd0, 5'd4, 5'd0);
        reserve(5'd4, 5'd4);
        repeat (2) idle(5'd4);

        // Write to r0 is granted but never reaches the register file.
        drive_cycle(1'b0, 3'b100, pa(0, 0, 0), pd(0, 0, 32'hFFFF_FFFF), 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0);

        // Double reservation raises a sticky error.
        reserve(5'd3, 5'd3);
        reserve(5'd3, 5'd3);
        repeat (4) idle(5'd3);
        drive_cycle(1'b1, '0, '0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd3);

        // Random traffic on a small register window so hazards and collisions recur.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                ra_v[i*AW +: AW] = 5'($urandom_range(0, 7));
                rd_v[i*DW +: DW] = $urandom;
            end
            drive_cycle(($urandom_range(0, 59) == 0), N'($urandom_range(0, 7)), ra_v, rd_v,
                        ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        repeat (3) idle(5'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
